// File: rtl/denise_colortable_ram_mf.sv
// Colour table RAM: 256 x 32 simple dual-port, byte-lane writes, registered read.
// Memory survives reset; only the read register is cleared.
module denise_colortable_ram_mf (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [7:0]  wraddress,
  input  logic        wren,
  input  logic [3:0]  byteena_a,
  input  logic [31:0] data,
  input  logic [7:0]  rdaddress,
  output logic [31:0] q
);

  // Power-up contents are zero; there is deliberately no reset path into the array.
  logic [31:0] mem [256] = '{default: 32'h0};

  logic wr_go;
  assign wr_go = enable && wren && reset_n;

  always_ff @(posedge clock) begin
    if (wr_go) begin
      for (int i = 0; i < 4; i++) begin
        if (byteena_a[i]) begin
          mem[wraddress][8*i +: 8] <= data[8*i +: 8];
        end
      end
    end
  end

  // Read samples the array before this edge's write lands, giving old-data on collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q <= 32'h0;
    end else if (enable) begin
      q <= mem[rdaddress];
    end
  end

endmodule

// File: tb/tb_denise_colortable_ram_mf.sv
// Bench for denise_colortable_ram_mf: array model checked every cycle plus directed literal checks.
module tb_denise_colortable_ram_mf;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  wraddress;
  logic        wren;
  logic [3:0]  byteena_a;
  logic [31:0] data;
  logic [7:0]  rdaddress;
  logic [31:0] q;

  int vectors = 0;
  int miscompares = 0;

  denise_colortable_ram_mf dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
    .wraddress (wraddress),
    .wren      (wren),
    .byteena_a (byteena_a),
    .data      (data),
    .rdaddress (rdaddress),
    .q         (q)
  );

  always #5 clock = ~clock;

  // Reference model: plain array with mask merge; read returns pre-write contents.
  logic [31:0] model_mem [256];
  logic [31:0] exp_q = 32'h0;
  initial for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;

  always @(posedge clock or negedge reset_n) begin
    logic [31:0] mask;
    if (!reset_n) begin
      exp_q = 32'h0;
    end else if (enable) begin
      exp_q = model_mem[rdaddress];
      if (wren) begin
        mask = {{8{byteena_a[3]}}, {8{byteena_a[2]}}, {8{byteena_a[1]}}, {8{byteena_a[0]}}};
        model_mem[wraddress] = (model_mem[wraddress] & ~mask) | (data & mask);
      end
    end
  end

  always @(negedge clock) begin
    vectors++;
    if (q !== exp_q) begin
      miscompares++;
      $display("FAIL model_cmp t=%0t q=%h expected=%h", $time, q, exp_q);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s q=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    enable = 1'b1; wren = 1'b1; wraddress = a; data = d; byteena_a = be;
    step();
    wren = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    enable = 1'b1; wren = 1'b0; rdaddress = a;
    step();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; wren = 1'b0; wraddress = 8'h0;
    byteena_a = 4'h0; data = 32'h0; rdaddress = 8'h0;
    repeat (3) step();
    check("reset_q", q, 32'h0);
    reset_n = 1'b1;

    rd(8'h00);
    check("powerup_zero", q, 32'h0);
    rd(8'h80);
    check("powerup_zero_80", q, 32'h0);

    for (int a = 0; a < 256; a++) wr(a[7:0], 32'hA5A5_0000 + a, 4'hF);
    for (int a = 0; a < 256; a++) begin
      rd(a[7:0]);
      check($sformatf("fill_%0d", a), q, 32'hA5A5_0000 + a);
    end

    wr(8'h10, 32'h1122_3344, 4'hF);
    wr(8'h10, 32'hFFFF_FFFF, 4'b0011);
    rd(8'h10);
    check("byteena_lo", q, 32'h1122_FFFF);
    wr(8'h10, 32'h0000_0000, 4'b0000);
    rd(8'h10);
    check("byteena_none", q, 32'h1122_FFFF);
    wr(8'h10, 32'hAB00_0000, 4'b1000);
    rd(8'h10);
    check("byteena_hi", q, 32'hAB22_FFFF);

    wr(8'h20, 32'h0000_0ABC, 4'hF);
    enable = 1'b1; wren = 1'b1; wraddress = 8'h20; data = 32'h0000_0123;
    byteena_a = 4'hF; rdaddress = 8'h20;
    step();
    wren = 1'b0;
    check("rdw_old", q, 32'h0000_0ABC);
    rd(8'h20);
    check("rdw_new", q, 32'h0000_0123);

    enable = 1'b1; wren = 1'b1; wraddress = 8'h30; data = 32'h0000_0077;
    byteena_a = 4'hF; rdaddress = 8'h20;
    step();
    wren = 1'b0;
    check("indep_rd", q, 32'h0000_0123);
    rd(8'h30);
    check("indep_wr", q, 32'h0000_0077);

    rd(8'h05);
    check("pre_gate", q, 32'hA5A5_0005);
    enable = 1'b0; wren = 1'b1; wraddress = 8'h05; data = 32'hDEAD_BEEF;
    byteena_a = 4'hF; rdaddress = 8'h07;
    step();
    check("gate_hold1", q, 32'hA5A5_0005);
    rdaddress = 8'h09;
    step();
    check("gate_hold2", q, 32'hA5A5_0005);
    wren = 1'b0;
    rd(8'h05);
    check("gate_nowrite", q, 32'hA5A5_0005);

    @(negedge clock);
    #2 reset_n = 1'b0;
    #1 check("async_reset", q, 32'h0);
    enable = 1'b1; wren = 1'b1; wraddress = 8'h05; data = 32'h0BAD_0BAD; byteena_a = 4'hF;
    step();
    check("reset_hold", q, 32'h0);
    wren = 1'b0;
    reset_n = 1'b1;
    rd(8'h05);
    check("post_reset_mem", q, 32'hA5A5_0005);

    wr(8'h00, 32'h0000_1111, 4'hF);
    wr(8'hFF, 32'hFFFF_0000, 4'hF);
    rd(8'h00);
    check("bound_00", q, 32'h0000_1111);
    rd(8'hFF);
    check("bound_ff", q, 32'hFFFF_0000);
    rd(8'h01);
    check("bound_01", q, 32'hA5A5_0001);
    rd(8'hFE);
    check("bound_fe", q, 32'hA5A5_00FE);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
